sequential_restoring_divider: RTL and testbench
===============================================

Name: sequential_restoring_divider

Overview:
- Iterative radix-2 restoring divider for unsigned integers. It is the inverse datapath of the pipelined array multiplier.
- Each cycle it performs one shift/trial-subtract row and produces one quotient bit, MSB first.
- Sits in the integer execution unit next to the multiplier. Serves DIV/DIVU/REM/REMU after operand sign handling upstream.
- Single-issue with a valid/idle handshake; one division in flight at a time.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits; power of 2, minimum 4.
- COUNTER_WIDTH, $clog2(DATA_WIDTH), width of the iteration counter; derived, do not override.

Ports:
- clk_i  input  1  system clock, rising-edge.
- rst_i  input  1  asynchronous active-high reset.
- clear_i  input  1  synchronous flush; aborts any operation.
- dividend_i  input  DATA_WIDTH  unsigned dividend.
- divisor_i  input  DATA_WIDTH  unsigned divisor.
- data_valid_i  input  1  operands valid; sampled only when idle_o=1.
- quotient_o  output  DATA_WIDTH  quotient.
- remainder_o  output  DATA_WIDTH  remainder.
- divide_by_zero_o  output  1  divisor was zero; qualified by data_valid_o.
- data_valid_o  output  1  one-cycle pulse, results valid.
- idle_o  output  1  unit can accept a new operation.

Behaviour:

Clock and reset:
- One clock. Reset is asynchronous and active-high: clk_i and rst_i.
- On reset: FSM=IDLE, quotient_o=0, remainder_o=0, divide_by_zero_o=0, data_valid_o=0, idle_o=1, counter=0.

FSM states IDLE, DIVIDE, DONE:
- IDLE: idle_o=1. If data_valid_i=1, latch the operands into internal registers: divisor register, quotient shift register (loaded with the dividend), partial remainder=0, counter=DATA_WIDTH-1, divide_by_zero = (divisor_i==0). Go to DIVIDE.
- DIVIDE: idle_o=0. Each cycle:
  - trial = {rem[DATA_WIDTH-2:0], q[DATA_WIDTH-1]} minus {0, divisor}, computed DATA_WIDTH+1 bits wide.
  - If trial MSB=0: rem=trial low bits and q={q[DATA_WIDTH-2:0],1}.
  - Otherwise: rem=the shifted value and q={q[DATA_WIDTH-2:0],0}.
  - When counter==0, go to DONE; otherwise decrement the counter.
- DONE: drive quotient_o, remainder_o and divide_by_zero_o from the internal registers. Assert data_valid_o for exactly this cycle, with idle_o=0. Go to IDLE.

Latency and results:
- Latency from the accept edge to data_valid_o high is DATA_WIDTH+1 cycles. A new accept is possible on the cycle after DONE.
- Outputs hold their values until the next DONE, clear_i or reset.
- Divisor zero: the normal algorithm yields quotient all-ones and remainder=dividend (RISC-V semantics). divide_by_zero_o=1 alongside data_valid_o.
- Dividend < divisor: quotient 0, remainder=dividend.

Handshake and flush:
- data_valid_i is ignored outside IDLE; no queueing, no error.
- clear_i=1 in any state: next state IDLE, counter=0, data_valid_o=0. Result outputs keep their last values.
- clear_i has priority over data_valid_i in the same cycle.
- Reset mid-DIVIDE aborts immediately; no data_valid_o follows.

Optional Feature:
- Macro: DIVIDER_ZERO_BYPASS_EN.
- Defined: in IDLE, an accept with divisor_i==0 goes directly to DONE. Results are quotient all-ones and remainder=dividend, with divide_by_zero_o=1. Latency is 1 cycle instead of DATA_WIDTH+1.
- Undefined: a zero divisor runs the full DATA_WIDTH iterations and produces identical result values with the normal latency.
- All other behaviour is identical in both builds.

Test Plan (DATA_WIDTH=8):
- Accept 100/7 at cycle 0 → data_valid_o at cycle 9, quotient_o=14, remainder_o=2, divide_by_zero_o=0; idle_o=0 on cycles 1-9.
- Accept 200/0:
  - Without the macro: cycle 9, quotient_o=255, remainder_o=200, divide_by_zero_o=1.
  - With DIVIDER_ZERO_BYPASS_EN: same values at cycle 1.
- Boundary cases: 5/9 → quotient 0, remainder 5; 255/1 → quotient 255, remainder 0; 255/255 → quotient 1, remainder 0.
- Hold data_valid_i=1 with new operands (50/3) during DIVIDE of 100/7 → ignored. 100/7 completes normally; 50/3 is accepted only in the cycle after DONE and returns quotient 16, remainder 2 after 9 more cycles.
- Assert clear_i at cycle 4 of 100/7 → no data_valid_o, idle_o=1 next cycle. Accept 9/2 immediately → quotient 4, remainder 1 at the normal latency.
- Assert rst_i asynchronously mid-DIVIDE (between clock edges) → outputs zero and idle_o=1 before the next edge; no stale data_valid_o after rst_i is released.

Source files
------------

// File: rtl/sequential_restoring_divider.sv
// Iterative radix-2 restoring divider, unsigned, one quotient bit per cycle, MSB first.
// Optional macro DIVIDER_ZERO_BYPASS_EN: a zero divisor skips the iterations and completes in one cycle.
module sequential_restoring_divider #(
  parameter int DATA_WIDTH    = 32,
  parameter int COUNTER_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  data_valid_i,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  divide_by_zero_o,
  output logic                  data_valid_o,
  output logic                  idle_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic [DATA_WIDTH-1:0]    r_divisor;
  logic [DATA_WIDTH-1:0]    r_q;
  logic [DATA_WIDTH-1:0]    r_rem;
  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic                     r_dbz;

  logic [DATA_WIDTH-1:0]    r_quotient;
  logic [DATA_WIDTH-1:0]    r_remainder;
  logic                     r_dbz_out;

  logic [DATA_WIDTH-1:0]    w_shifted;
  logic [DATA_WIDTH:0]      w_trial;
  logic                     w_fits;
  logic [DATA_WIDTH-1:0]    w_rem_next;
  logic [DATA_WIDTH-1:0]    w_q_next;
  logic                     w_div_zero;
  logic                     w_cnt_zero;

  // Before the final shift the partial remainder is below 2^(W-1), so dropping its MSB loses nothing.
  assign w_shifted  = {r_rem[DATA_WIDTH-2:0], r_q[DATA_WIDTH-1]};
  assign w_trial    = {1'b0, w_shifted} - {1'b0, r_divisor};
  assign w_fits     = ~w_trial[DATA_WIDTH];
  assign w_rem_next = w_fits ? w_trial[DATA_WIDTH-1:0] : w_shifted;
  assign w_q_next   = {r_q[DATA_WIDTH-2:0], w_fits};
  assign w_div_zero = (divisor_i == '0);
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    idle_o       = 1'b0;
    data_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        idle_o = 1'b1;
        if (data_valid_i) begin
`ifdef DIVIDER_ZERO_BYPASS_EN
          w_state_next = w_div_zero ? S_DONE : S_DIVIDE;
`else
          w_state_next = S_DIVIDE;
`endif
        end
      end
      S_DIVIDE: begin
        if (w_cnt_zero) w_state_next = S_DONE;
      end
      S_DONE: begin
        data_valid_o = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // Flush wins over everything, including a pending result pulse.
    if (clear_i) begin
      w_state_next = S_IDLE;
      data_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_divisor   <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz_out   <= 1'b0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_valid_i) begin
            r_divisor <= divisor_i;
            r_q       <= dividend_i;
            r_rem     <= '0;
            r_cnt     <= COUNTER_WIDTH'(DATA_WIDTH - 1);
            r_dbz     <= w_div_zero;
`ifdef DIVIDER_ZERO_BYPASS_EN
            if (w_div_zero) begin
              r_cnt       <= '0;
              r_quotient  <= '1;
              r_remainder <= dividend_i;
              r_dbz_out   <= 1'b1;
            end
`endif
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          // Publish on the last iteration so results are stable throughout DONE.
          if (w_cnt_zero) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next;
            r_dbz_out   <= r_dbz;
          end else begin
            r_cnt <= r_cnt - COUNTER_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient_o       = r_quotient;
  assign remainder_o      = r_remainder;
  assign divide_by_zero_o = r_dbz_out;

endmodule

// File: tb/tb_sequential_restoring_divider.sv
// Directed bench for sequential_restoring_divider at DATA_WIDTH=8; honours DIVIDER_ZERO_BYPASS_EN.
module tb_sequential_restoring_divider;

  localparam int W = 8;
`ifdef DIVIDER_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_i, clear_i, data_valid_i;
  logic [W-1:0] dividend_i, divisor_i;
  logic [W-1:0] quotient_o, remainder_o;
  logic         divide_by_zero_o, data_valid_o, idle_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sequential_restoring_divider #(.DATA_WIDTH(W)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .dividend_i      (dividend_i),
    .divisor_i       (divisor_i),
    .data_valid_i    (data_valid_i),
    .quotient_o      (quotient_o),
    .remainder_o     (remainder_o),
    .divide_by_zero_o(divide_by_zero_o),
    .data_valid_o    (data_valid_o),
    .idle_o          (idle_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the result pulse; returns cycles since the accept edge.
  task automatic wait_result(output int lat, output bit busy_ok);
    bit seen = 0;
    lat = 0;
    busy_ok = 1;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (idle_o !== 1'b0) busy_ok = 0;
      if (data_valid_o === 1'b1) seen = 1;
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after DONE.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                         input int elat);
    int  lat;
    bit  busy_ok;
    dividend_i   = a;
    divisor_i    = b;
    data_valid_i = 1'b1;
    @(posedge clk);
    #1 data_valid_i = 1'b0;
    wait_result(lat, busy_ok);
    check({tag, "_lat"},  lat, elat);
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_q"},    quotient_o, eq);
    check({tag, "_r"},    remainder_o, er);
    check({tag, "_dbz"},  divide_by_zero_o, ez);
    @(negedge clk);
    check({tag, "_pulse"}, data_valid_o, 0);
    check({tag, "_idle"},  idle_o, 1);
    check({tag, "_hold"},  quotient_o, eq);
  endtask

  initial begin
    int  lat;
    bit  busy_ok;
    int  dv_seen;
    rst_i        = 1'b1;
    clear_i      = 1'b0;
    data_valid_i = 1'b0;
    dividend_i   = '0;
    divisor_i    = '0;
    repeat (2) @(negedge clk);
    check("rst_q",    quotient_o, 0);
    check("rst_r",    remainder_o, 0);
    check("rst_dbz",  divide_by_zero_o, 0);
    check("rst_dv",   data_valid_o, 0);
    check("rst_idle", idle_o, 1);
    rst_i = 1'b0;
    @(negedge clk);

    run_div("d100_7",  8'd100, 8'd7,   8'd14,  8'd2,   1'b0, W + 1);
    run_div("d200_0",  8'd200, 8'd0,   8'd255, 8'd200, 1'b1, ZLAT);
    run_div("d5_9",    8'd5,   8'd9,   8'd0,   8'd5,   1'b0, W + 1);
    run_div("d255_1",  8'd255, 8'd1,   8'd255, 8'd0,   1'b0, W + 1);
    run_div("d255_255",8'd255, 8'd255, 8'd1,   8'd0,   1'b0, W + 1);

    // data_valid_i held high with new operands while busy must be ignored
    dividend_i   = 8'd100;
    divisor_i    = 8'd7;
    data_valid_i = 1'b1;
    @(posedge clk);
    #1;
    dividend_i = 8'd50;
    divisor_i  = 8'd3;
    wait_result(lat, busy_ok);
    check("ign_first_lat", lat, W + 1);
    check("ign_first_busy", busy_ok, 1);
    check("ign_first_q", quotient_o, 14);
    check("ign_first_r", remainder_o, 2);
    @(negedge clk);
    check("ign_gap_idle", idle_o, 1);
    check("ign_gap_dv", data_valid_o, 0);
    @(posedge clk);
    #1 data_valid_i = 1'b0;
    wait_result(lat, busy_ok);
    check("ign_second_lat", lat, W + 1);
    check("ign_second_q", quotient_o, 16);
    check("ign_second_r", remainder_o, 2);
    @(negedge clk);

    // clear mid-divide: no result pulse, outputs keep the 50/3 values
    dividend_i   = 8'd100;
    divisor_i    = 8'd7;
    data_valid_i = 1'b1;
    @(posedge clk);
    #1 data_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    clear_i = 1'b1;
    @(posedge clk);
    #1 clear_i = 1'b0;
    @(negedge clk);
    check("clr_idle", idle_o, 1);
    check("clr_dv", data_valid_o, 0);
    check("clr_keep_q", quotient_o, 16);
    check("clr_keep_r", remainder_o, 2);
    run_div("clr_next", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, W + 1);

    // asynchronous reset between edges mid-divide
    dividend_i   = 8'd100;
    divisor_i    = 8'd7;
    data_valid_i = 1'b1;
    @(posedge clk);
    #1 data_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("arst_q",    quotient_o, 0);
    check("arst_r",    remainder_o, 0);
    check("arst_dbz",  divide_by_zero_o, 0);
    check("arst_dv",   data_valid_o, 0);
    check("arst_idle", idle_o, 1);
    @(negedge clk);
    rst_i = 1'b0;
    dv_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (data_valid_o !== 1'b0) dv_seen++;
    end
    check("arst_no_stale_dv", dv_seen, 0);
    check("arst_idle_after", idle_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
